mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised MEM-stage load/store engine, little-endian. Handles byte, half and word accesses
//  with byte enables, lane replication and sign/zero extension. Decodes the UART MMIO window.
//  Drives a synchronous data RAM through a wait-state FSM and raises stall to freeze the pipeline.
// PARAMETERS
//  ADDR_W          32            byte-address width
//  RAM_WAIT        1             extra RAM wait cycles (0..2**WAIT_W-1)
//  WAIT_W          3             wait counter width
//  UART_DATA_ADDR  32'hBFD003F8  UART data register (byte address)
//  UART_STAT_ADDR  32'hBFD003FC  UART status register: {30'b0,recv_flag,send_flag}
// PORTS
//  clk             in   1         clock, rising edge
//  rst_n           in   1         async active-low reset
//  req_valid       in   1         load/store present in MEM this cycle; held stable while stall=1
//  req_we          in   1         1=store, 0=load
//  req_size        in   2         00 byte, 01 half, 10 word, 11 reserved
//  req_signed      in   1         sign-extend load result
//  req_addr        in   ADDR_W    byte address
//  req_wdata       in   32        store data (low bits significant)
//  stall           out  1         freeze pipeline
//  rdata           out  32        load result
//  addr_err        out  1         misaligned or reserved-size request
//  ram_ce/ram_we   out  1/1       RAM enable / write
//  ram_be          out  4         byte enables
//  ram_addr        out  ADDR_W-2  word address (req_addr>>2)
//  ram_wdata       out  32        lane-replicated store data
//  ram_rdata       in   32        RAM read data
//  uart_wdata      out  8         UART tx byte
//  uart_we         out  1         UART tx strobe (1-cycle pulse)
//  uart_rd         out  1         clear-receive-flag pulse
//  uart_rdata      in   8         UART rx byte
//  uart_recv_flag  in   1         UART receive flag
//  uart_send_flag  in   1         UART send flag
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; every output 0, asserted immediately on rst_n fall.
//  addr_err (comb, IDLE only): size 11, half with addr[0]=1, or word with addr[1:0]!=0.
//   When set: no RAM/UART side effects, stall=0, rdata=0.
//  Lanes:
//   byte: be=4'b0001<<addr[1:0], wdata={4{d[7:0]}}
//   half: be=addr[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}
//   word: be=4'b1111, wdata=d
//  Load extract: lane selected by addr[1:0]; extended per req_signed.
//  MMIO, IDLE, no stall:
//   UART_DATA store: uart_wdata<=d[7:0]; uart_we=1 in the next cycle only.
//   UART_DATA load: rdata={24'b0,uart_rdata} comb; uart_rd=1 in the next cycle only.
//   UART_STAT load: rdata={30'b0,recv,send} comb.
//   UART_STAT store: ignored.
//  FSM states IDLE, WAIT, DONE.
//   IDLE: req_valid & RAM region & !addr_err -> stall=1 comb. Edge: latch addr/be/wdata/we,
//    cnt<=RAM_WAIT, go to WAIT.
//   WAIT: ram_ce=1 with registered ram_* ; stall=1. cnt!=0 -> cnt-1.
//    cnt==0 -> load captures formatted ram_rdata into rdata_q; go to DONE.
//   DONE: stall=0, rdata=rdata_q, ram_ce=0; unconditionally return to IDLE.
//    The same held req is never re-accepted.
//  Latency: stall high RAM_WAIT+2 cycles, rdata valid in DONE. Write occurs on every WAIT cycle
//   (idempotent).
//  rdata=0 outside DONE and MMIO loads. ram_we=ram_ce&latched_we.
//  rst_n low in WAIT/DONE: access aborted, ram_ce/stall drop async, IDLE after release.
// TESTING
//  RAM_WAIT=2, lw 0x80000010, ram_rdata=0x11223344 -> stall 4 cycles;
//   ram_ce 3 cycles with ram_addr=0x20000004, be=1111; DONE rdata=0x11223344.
//  lb 0x80000013 signed, ram_rdata=0x80FF7F01 -> rdata=0xFFFFFF80; lbu same addr -> 0x00000080.
//  sh 0x80000002, wdata=0x0000BEEF -> ram_we=1, be=1100, ram_wdata=0xBEEFBEEF.
//  sw UART_DATA_ADDR, wdata=0x41 -> stall 0, ram_ce 0; next cycle uart_we=1 once, uart_wdata=0x41.
//  lw UART_STAT, recv=1 send=0 -> rdata=0x2 same cycle;
//   lw UART_DATA, uart_rdata=0x5A -> rdata=0x5A, uart_rd pulse next cycle.
//  lw 0x80000002 -> addr_err=1, stall 0, ram_ce 0;
//   rst_n low mid-WAIT -> stall/ram_ce 0 immediately, IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: lane steering, load extension, UART MMIO decode,
// and a wait-state FSM that drives a synchronous data RAM while stalling the pipeline.
module mem_access_unit #(
    parameter int              ADDR_W         = 32,
    parameter int              RAM_WAIT       = 1,
    parameter int              WAIT_W         = 3,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(32'hBFD003F8),
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(32'hBFD003FC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        uart_wdata,
    output logic              uart_we,
    output logic              uart_rd,
    input  logic [7:0]        uart_rdata,
    input  logic              uart_recv_flag,
    input  logic              uart_send_flag
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_n;
    logic [WAIT_W-1:0]   cnt;
    logic [ADDR_W-3:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [1:0]          off_q;
    logic                signed_q;
    logic [31:0]         rdata_q;

    logic [1:0]          off;
    logic                err_c;
    logic                hit_data;
    logic                hit_stat;
    logic                go;
    logic                ram_go;
    logic                stall_c;
    logic [3:0]          be_c;
    logic [31:0]         wdata_c;

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] o, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   fmt_load = {{24{sgn & b[7]}}, b};
            2'b01:   fmt_load = {{16{sgn & h[15]}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    assign off      = req_addr[1:0];
    assign hit_data = (req_addr[ADDR_W-1:2] == UART_DATA_ADDR[ADDR_W-1:2]);
    assign hit_stat = (req_addr[ADDR_W-1:2] == UART_STAT_ADDR[ADDR_W-1:2]);

    // Errors are only meaningful for a fresh request; an erroneous one has no side effects.
    always_comb begin
        err_c = 1'b0;
        if (state == IDLE && req_valid) begin
            err_c = (req_size == 2'b11) ||
                    (req_size == 2'b01 && off[0]) ||
                    (req_size == 2'b10 && off != 2'b00);
        end
    end

    assign go       = (state == IDLE) && req_valid && !err_c;
    assign ram_go   = go && !hit_data && !hit_stat;
    assign addr_err = rst_n & err_c;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
        case (req_size)
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        stall_c = 1'b0;
        case (state)
            IDLE: begin
                if (ram_go) begin
                    stall_c = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt == '0) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Access latches, wait counter, load capture and the one-cycle UART strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            signed_q   <= 1'b0;
            rdata_q    <= '0;
            uart_wdata <= '0;
            uart_we    <= 1'b0;
            uart_rd    <= 1'b0;
        end else begin
            uart_we <= go && hit_data && req_we;
            uart_rd <= go && hit_data && !req_we;
            if (go && hit_data && req_we) uart_wdata <= req_wdata[7:0];
            if (ram_go) begin
                addr_q   <= req_addr[ADDR_W-1:2];
                be_q     <= be_c;
                wdata_q  <= wdata_c;
                we_q     <= req_we;
                size_q   <= req_size;
                off_q    <= off;
                signed_q <= req_signed;
                cnt      <= WAIT_W'(RAM_WAIT);
            end else if (state == WAIT) begin
                if (cnt != '0) cnt <= cnt - WAIT_W'(1);
                else           rdata_q <= we_q ? 32'd0 : fmt_load(ram_rdata, size_q, off_q, signed_q);
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (rst_n) begin
            if (state == DONE) begin
                rdata = rdata_q;
            end else if (go && !req_we && hit_data) begin
                rdata = {24'd0, uart_rdata};
            end else if (go && !req_we && hit_stat) begin
                rdata = {30'd0, uart_recv_flag, uart_send_flag};
            end
        end
    end

    assign stall     = rst_n & stall_c;
    assign ram_ce    = (state == WAIT);
    assign ram_we    = ram_ce & we_q;
    assign ram_be    = be_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single-cycle MMIO/error vectors
// plus hand-written multi-cycle RAM, lane and reset-abort sequences.
module tb_mem_access_unit;

    localparam logic [31:0] UDATA = 32'hBFD003F8;
    localparam logic [31:0] USTAT = 32'hBFD003FC;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        addr_err;
    logic        ram_ce;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  uart_wdata;
    logic        uart_we;
    logic        uart_rd;
    logic [7:0]  uart_rdata;
    logic        uart_recv_flag;
    logic        uart_send_flag;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_unit #(.ADDR_W(32), .RAM_WAIT(2), .WAIT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .addr_err(addr_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .uart_wdata(uart_wdata), .uart_we(uart_we), .uart_rd(uart_rd),
        .uart_rdata(uart_rdata), .uart_recv_flag(uart_recv_flag),
        .uart_send_flag(uart_send_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  urx;
        logic        recv;
        logic        send;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_uwe;
        logic        exp_urd;
        logic [7:0]  exp_uwdata;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    // Runs one RAM access from IDLE (called just after a negedge) until stall drops.
    task automatic ramAccess(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                             output int stall_cyc, output int ce_cyc, output logic [31:0] done_rdata,
                             output logic saw_we, output logic [3:0] be_seen,
                             output logic [29:0] addr_seen, output logic [31:0] wdata_seen,
                             output logic timed_out);
        stall_cyc  = 0;
        ce_cyc     = 0;
        done_rdata = 32'hDEADDEAD;
        saw_we     = 1'b0;
        be_seen    = 4'h0;
        addr_seen  = '0;
        wdata_seen = 32'h0;
        timed_out  = 1'b1;
        ram_rdata  = rd;
        applyStimulus(we, size, sgn, addr, wdata);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall) stall_cyc++;
            if (ram_ce) begin
                ce_cyc++;
                saw_we     = ram_we;
                be_seen    = ram_be;
                addr_seen  = ram_addr;
                wdata_seen = ram_wdata;
            end
            if (!stall) begin
                done_rdata = rdata;
                timed_out  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    int          sc, cc;
    logic [31:0] dr;
    logic        swe, tmo;
    logic [3:0]  sbe;
    logic [29:0] sad;
    logic [31:0] swd;

    initial begin
        rst_n = 1'b0;
        ram_rdata = 32'h0;
        uart_rdata = 8'h0;
        uart_recv_flag = 1'b0;
        uart_send_flag = 1'b0;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0);

        //                 we  size   sgn   addr          wdata         urx    rv    sd    err   rdata         uwe   urd   uwd
        vecs[0]  = '{1'b0, 2'b10, 1'b0, USTAT,        32'h0,        8'h00, 1'b1, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, USTAT,        32'h0,        8'h00, 1'b0, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, UDATA,        32'h0,        8'h5A, 1'b1, 1'b0, 1'b0, 32'h0000005A, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, UDATA,        32'h0,        8'hC3, 1'b1, 1'b1, 1'b0, 32'h000000C3, 1'b0, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, UDATA,        32'h00000041, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'h41};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, UDATA,        32'h00001234, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'h34};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, USTAT,        32'h00000055, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h80000002, 32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h80000001, 32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h80000000, 32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'hBFD003F9, 32'h00000077, 8'h00, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 2'b01, 1'b0, UDATA,        32'h0,        8'h99, 1'b0, 1'b0, 1'b0, 32'h00000099, 1'b0, 1'b1, 8'h00};

        // Reset state, with a valid RAM request present to prove outputs are forced low.
        #2;
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset ram_ce", {31'd0, ram_ce}, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset uart strobes", {30'd0, uart_we, uart_rd}, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            uart_rdata     = vecs[i].urx;
            uart_recv_flag = vecs[i].recv;
            uart_send_flag = vecs[i].send;
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
            #1;
            checkOutput($sformatf("v%0d addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].exp_err});
            checkOutput($sformatf("v%0d stall", i), {31'd0, stall}, 32'd0);
            checkOutput($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            checkOutput($sformatf("v%0d ram_ce", i), {31'd0, ram_ce}, 32'd0);
            checkOutput($sformatf("v%0d uart_we", i), {31'd0, uart_we}, {31'd0, vecs[i].exp_uwe});
            checkOutput($sformatf("v%0d uart_rd", i), {31'd0, uart_rd}, {31'd0, vecs[i].exp_urd});
            if (vecs[i].exp_uwe)
                checkOutput($sformatf("v%0d uart_wdata", i), {24'd0, uart_wdata}, {24'd0, vecs[i].exp_uwdata});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d strobes drop", i), {30'd0, uart_we, uart_rd}, 32'd0);
            @(negedge clk);
        end

        // Word load through the wait-state FSM.
        ramAccess(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0, 32'h11223344, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("lw timeout", {31'd0, tmo}, 32'd0);
        checkOutput("lw stall cycles", sc, 32'd4);
        checkOutput("lw ram_ce cycles", cc, 32'd3);
        checkOutput("lw ram_addr", {2'b00, sad}, 32'h20000004);
        checkOutput("lw ram_be", {28'd0, sbe}, 32'hF);
        checkOutput("lw ram_we", {31'd0, swe}, 32'd0);
        checkOutput("lw rdata", dr, 32'h11223344);
        #1;
        checkOutput("rdata after DONE", rdata, 32'd0);

        ramAccess(1'b0, 2'b00, 1'b1, 32'h80000013, 32'h0, 32'h80FF7F01, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("lb signed rdata", dr, 32'hFFFFFF80);
        checkOutput("lb ram_be", {28'd0, sbe}, 32'h8);
        ramAccess(1'b0, 2'b00, 1'b0, 32'h80000013, 32'h0, 32'h80FF7F01, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("lbu rdata", dr, 32'h00000080);
        ramAccess(1'b0, 2'b01, 1'b1, 32'h80000002, 32'h0, 32'h80FF7F01, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("lh signed rdata", dr, 32'hFFFF80FF);
        ramAccess(1'b0, 2'b00, 1'b1, 32'h80000001, 32'h0, 32'h80FF7F01, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("lb signed lane1", dr, 32'h0000007F);

        ramAccess(1'b1, 2'b01, 1'b0, 32'h80000002, 32'h0000BEEF, 32'h0, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("sh ram_we", {31'd0, swe}, 32'd1);
        checkOutput("sh ram_be", {28'd0, sbe}, 32'hC);
        checkOutput("sh ram_wdata", swd, 32'hBEEFBEEF);
        checkOutput("sh stall cycles", sc, 32'd4);
        ramAccess(1'b1, 2'b00, 1'b0, 32'h80000001, 32'h000000A5, 32'h0, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("sb ram_be", {28'd0, sbe}, 32'h2);
        checkOutput("sb ram_wdata", swd, 32'hA5A5A5A5);

        // Reset asserted while the RAM access is in WAIT.
        ram_rdata = 32'h11223344;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("pre-abort ram_ce", {31'd0, ram_ce}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort stall", {31'd0, stall}, 32'd0);
        checkOutput("abort ram_ce", {31'd0, ram_ce}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-abort ram_ce", {31'd0, ram_ce}, 32'd0);
        checkOutput("post-abort stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        ramAccess(1'b0, 2'b10, 1'b0, 32'h80000010, 32'h0, 32'h11223344, sc, cc, dr, swe, sbe, sad, swd, tmo);
        checkOutput("post-abort lw stall cycles", sc, 32'd4);
        checkOutput("post-abort lw rdata", dr, 32'h11223344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
